// File: rtl/vec_cat_stream.sv
// Unpacks back-to-back packed fingerprints from a bus-word stream into vector-aligned, zero-padded bus words.
// Optional build macro VEC_CAT_POPCNT_EN adds o_PopCnt (per-vector popcount presented with o_Last).
module vec_cat_stream #(
    parameter int unsigned BUS_WIDTH    = 96,
    parameter int unsigned VECTOR_WIDTH = 128,
    parameter int unsigned VEC_ID_WIDTH = 8
`ifdef VEC_CAT_POPCNT_EN
    ,
    localparam int unsigned PCW = $clog2(VECTOR_WIDTH + 1)
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUS_WIDTH-1:0]    i_Vector,
    input  logic                    i_Valid,
    output logic                    o_Read,
    output logic [BUS_WIDTH-1:0]    o_Vector,
    output logic                    o_Valid,
    input  logic                    i_Ready,
    output logic [VEC_ID_WIDTH-1:0] o_VecID,
    output logic                    o_Last
`ifdef VEC_CAT_POPCNT_EN
    ,
    output logic [PCW-1:0]          o_PopCnt
`endif
);

    localparam int unsigned WPV = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int unsigned REM = VECTOR_WIDTH - (WPV - 1) * BUS_WIDTH;
    localparam int unsigned PHW = (WPV > 1) ? $clog2(WPV) : 1;
    localparam int unsigned DW  = 2 * BUS_WIDTH;
    localparam int unsigned CW  = $clog2(DW + 1);

    // Residue keeps its valid bits MSB-aligned with all bits below the count at zero
    logic [BUS_WIDTH-1:0]    res_buf;
    logic [CW-1:0]           res_cnt;
    logic [PHW-1:0]          phase;
    logic [VEC_ID_WIDTH-1:0] gen_id;

    logic [CW-1:0]           need;
    logic [CW-1:0]           avail;
    logic                    last;
    logic                    out_free;
    logic                    res_ok;
    logic                    take;
    logic                    load;
    logic [DW-1:0]           src;
    logic [BUS_WIDTH-1:0]    word;
    logic [BUS_WIDTH-1:0]    rest;

    // Assemble the next output word from residue plus (optionally) the FIFO head
    always_comb begin
        last     = (phase == PHW'(WPV - 1));
        need     = last ? CW'(REM) : CW'(BUS_WIDTH);
        out_free = ~o_Valid | i_Ready;
        res_ok   = (res_cnt >= need);
        take     = i_Valid & ~rst & ~res_ok & out_free;
        load     = out_free & (res_ok | take);
        src      = {res_buf, {BUS_WIDTH{1'b0}}};
        if (take) begin
            src = src | ({i_Vector, {BUS_WIDTH{1'b0}}} >> res_cnt);
        end
        avail    = take ? (res_cnt + CW'(BUS_WIDTH)) : res_cnt;
        word     = src[DW-1 -: BUS_WIDTH] & ~({BUS_WIDTH{1'b1}} >> need);
        rest     = BUS_WIDTH'((src << need) >> BUS_WIDTH);
    end

    assign o_Read = take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_Vector <= '0;
            o_Valid  <= 1'b0;
            o_VecID  <= '0;
            o_Last   <= 1'b0;
            res_buf  <= '0;
            res_cnt  <= '0;
            phase    <= '0;
            gen_id   <= '0;
        end else if (load) begin
            o_Vector <= word;
            o_Valid  <= 1'b1;
            o_VecID  <= gen_id;
            o_Last   <= last;
            res_buf  <= rest;
            res_cnt  <= avail - need;
            if (last) begin
                phase  <= '0;
                gen_id <= gen_id + VEC_ID_WIDTH'(1);
            end else begin
                phase  <= phase + PHW'(1);
            end
        end else if (i_Ready) begin
            o_Valid  <= 1'b0;
        end
    end

`ifdef VEC_CAT_POPCNT_EN
    logic [PCW-1:0] word_pc;
    logic [PCW-1:0] pop_acc;

    // Padding bits are already zero in word, so they never contribute
    always_comb begin
        word_pc = '0;
        for (int i = 0; i < int'(BUS_WIDTH); i++) begin
            word_pc = word_pc + PCW'(word[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_acc  <= '0;
            o_PopCnt <= '0;
        end else if (load) begin
            if (last) begin
                o_PopCnt <= pop_acc + word_pc;
                pop_acc  <= '0;
            end else begin
                o_PopCnt <= '0;
                pop_acc  <= pop_acc + word_pc;
            end
        end else if (o_Valid & i_Ready & o_Last) begin
            o_PopCnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_vec_cat_stream.sv
// Directed bench for vec_cat_stream: 96/128 main instance, 64/128 with 2-bit IDs, 96/40 narrow vectors.
// Define VEC_CAT_POPCNT_EN for both RTL and bench to exercise the popcount path.
module tb_vec_cat_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [95:0] iv   [3];
    logic        ival [3];
    logic        irdy [3];
    logic [95:0] ov   [3];
    logic [7:0]  oid  [3];
    logic        oval [3];
    logic        olast[3];
    logic        ord  [3];

    logic [95:0] ov_a, ov_c;
    logic [63:0] ov_b;
    logic [7:0]  oid_a, oid_c;
    logic [1:0]  oid_b;
    logic        ord_a, ord_b, ord_c, oval_a, oval_b, oval_c, olast_a, olast_b, olast_c;
`ifdef VEC_CAT_POPCNT_EN
    logic [7:0]  pop_a, pop_b;
    logic [5:0]  pop_c;
    logic [7:0]  cap_pop[32];
`endif

    vec_cat_stream #(.BUS_WIDTH(96), .VECTOR_WIDTH(128), .VEC_ID_WIDTH(8)) u_a (
        .clk(clk), .rst(rst), .i_Vector(iv[0]), .i_Valid(ival[0]), .o_Read(ord_a),
        .o_Vector(ov_a), .o_Valid(oval_a), .i_Ready(irdy[0]), .o_VecID(oid_a), .o_Last(olast_a)
`ifdef VEC_CAT_POPCNT_EN
        , .o_PopCnt(pop_a)
`endif
    );
    vec_cat_stream #(.BUS_WIDTH(64), .VECTOR_WIDTH(128), .VEC_ID_WIDTH(2)) u_b (
        .clk(clk), .rst(rst), .i_Vector(iv[1][63:0]), .i_Valid(ival[1]), .o_Read(ord_b),
        .o_Vector(ov_b), .o_Valid(oval_b), .i_Ready(irdy[1]), .o_VecID(oid_b), .o_Last(olast_b)
`ifdef VEC_CAT_POPCNT_EN
        , .o_PopCnt(pop_b)
`endif
    );
    vec_cat_stream #(.BUS_WIDTH(96), .VECTOR_WIDTH(40), .VEC_ID_WIDTH(8)) u_c (
        .clk(clk), .rst(rst), .i_Vector(iv[2]), .i_Valid(ival[2]), .o_Read(ord_c),
        .o_Vector(ov_c), .o_Valid(oval_c), .i_Ready(irdy[2]), .o_VecID(oid_c), .o_Last(olast_c)
`ifdef VEC_CAT_POPCNT_EN
        , .o_PopCnt(pop_c)
`endif
    );

    assign ov[0] = ov_a;    assign ov[1] = {32'h0, ov_b};    assign ov[2] = ov_c;
    assign oid[0] = oid_a;  assign oid[1] = {6'h0, oid_b};   assign oid[2] = oid_c;
    assign oval[0] = oval_a;  assign oval[1] = oval_b;  assign oval[2] = oval_c;
    assign olast[0] = olast_a; assign olast[1] = olast_b; assign olast[2] = olast_c;
    assign ord[0] = ord_a;  assign ord[1] = ord_b;  assign ord[2] = ord_c;

    logic [95:0] in_mem [3][16];
    logic [95:0] cap_vec[3][32];
    logic [7:0]  cap_id [3][32];
    logic        cap_last[3][32];
    int in_len[3], in_ptr[3], out_cnt[3], rd_cnt[3];
    int stall_at[3], stall_left[3], stall_reads[3], gap_ptr[3], gap_left[3];
    bit stall_first[3], stall_bad[3], stalling[3];
    logic [95:0] snap_v[3];
    logic [7:0]  snap_id[3];
    logic        snap_l[3];
    int viol = 0;
    int n_checks = 0;
    int n_pass = 0;

    logic [95:0] gold_v[4];
    logic [7:0]  gold_id[4];
    logic        gold_l[4];

    // FIFO model + downstream sink: drive at negedge, sample handshakes just after
    always begin
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            bit gapping;
            stalling[g] = (out_cnt[g] == stall_at[g]) && (stall_left[g] > 0);
            gapping     = (in_ptr[g] == gap_ptr[g]) && (gap_left[g] > 0);
            if (gapping) gap_left[g]--;
            ival[g] = !gapping && (in_ptr[g] < in_len[g]);
            iv[g]   = ival[g] ? in_mem[g][in_ptr[g]] : 96'h0;
            irdy[g] = !stalling[g];
        end
        #1;
        for (int g = 0; g < 3; g++) begin
            if (ord[g] && !ival[g]) viol++;
            if (ord[g]) begin rd_cnt[g]++; in_ptr[g]++; end
            if (stalling[g]) begin
                if (ord[g]) stall_reads[g]++;
                if (stall_first[g]) begin
                    snap_v[g] = ov[g]; snap_id[g] = oid[g]; snap_l[g] = olast[g];
                    stall_first[g] = 1'b0;
                    if (oval[g] !== 1'b1) stall_bad[g] = 1'b1;
                end else if (ov[g] !== snap_v[g] || oid[g] !== snap_id[g] ||
                             olast[g] !== snap_l[g] || oval[g] !== 1'b1) begin
                    stall_bad[g] = 1'b1;
                end
                stall_left[g]--;
            end
            if (oval[g] && irdy[g] && out_cnt[g] < 32) begin
                cap_vec[g][out_cnt[g]]  = ov[g];
                cap_id[g][out_cnt[g]]   = oid[g];
                cap_last[g][out_cnt[g]] = olast[g];
`ifdef VEC_CAT_POPCNT_EN
                if (g == 0) cap_pop[out_cnt[0]] = pop_a;
`endif
                out_cnt[g]++;
            end
        end
    end

    task automatic clear_ctrl();
        for (int g = 0; g < 3; g++) begin
            in_len[g] = 0; in_ptr[g] = 0; out_cnt[g] = 0; rd_cnt[g] = 0;
            stall_at[g] = -1; stall_left[g] = 0; stall_reads[g] = 0;
            stall_first[g] = 1'b1; stall_bad[g] = 1'b0; gap_ptr[g] = -1; gap_left[g] = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        clear_ctrl();
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic load_gold();
        in_mem[0][0] = 96'h0123456789ABCDEF_FEDCBA98;
        in_mem[0][1] = 96'h76543210_DEADBEEF_CAFEBABE;
        in_mem[0][2] = 96'h01234567_89ABCDEF_00000000;
        in_len[0] = 3;
    endtask

    task automatic wait_out(input int g, input int n);
        for (int c = 0; c < 400 && out_cnt[g] < n; c++) @(posedge clk);
        repeat (6) @(posedge clk);
        #2;
    endtask

    task automatic check_gold(input string tag);
        n_checks++; if (out_cnt[0] !== 4) $display("FAIL %s count: got %0d want 4", tag, out_cnt[0]); else n_pass++;
        n_checks++; if (rd_cnt[0] !== 3) $display("FAIL %s reads: got %0d want 3", tag, rd_cnt[0]); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (cap_vec[0][k] !== gold_v[k]) $display("FAIL %s word%0d: got %h want %h", tag, k, cap_vec[0][k], gold_v[k]); else n_pass++;
            n_checks++; if (cap_id[0][k] !== gold_id[k]) $display("FAIL %s id%0d: got %0d want %0d", tag, k, cap_id[0][k], gold_id[k]); else n_pass++;
            n_checks++; if (cap_last[0][k] !== gold_l[k]) $display("FAIL %s last%0d: got %b want %b", tag, k, cap_last[0][k], gold_l[k]); else n_pass++;
        end
    endtask

    task automatic test_reset();
        clear_ctrl();
        load_gold();
        repeat (2) @(negedge clk);
        #2;
        n_checks++; if (oval[0] !== 1'b0) $display("FAIL rst_valid: got %b want 0", oval[0]); else n_pass++;
        n_checks++; if (ov[0] !== 96'h0) $display("FAIL rst_vector: got %h want 0", ov[0]); else n_pass++;
        n_checks++; if (oid[0] !== 8'h0) $display("FAIL rst_id: got %0d want 0", oid[0]); else n_pass++;
        n_checks++; if (olast[0] !== 1'b0) $display("FAIL rst_last: got %b want 0", olast[0]); else n_pass++;
        n_checks++; if (ord[0] !== 1'b0) $display("FAIL rst_read: got %b want 0 (i_Valid=%b)", ord[0], ival[0]); else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        load_gold();
        wait_out(0, 4);
        check_gold("basic");
    endtask

    task automatic test_stall();
        do_reset();
        stall_at[0] = 1; stall_left[0] = 5;
        load_gold();
        wait_out(0, 4);
        n_checks++; if (stall_left[0] !== 0) $display("FAIL stall_done: got %0d left want 0", stall_left[0]); else n_pass++;
        n_checks++; if (stall_reads[0] !== 0) $display("FAIL stall_reads: got %0d want 0", stall_reads[0]); else n_pass++;
        n_checks++; if (stall_bad[0] !== 1'b0) $display("FAIL stall_hold: outputs moved, got %b want 0", stall_bad[0]); else n_pass++;
        check_gold("stall");
    endtask

    task automatic test_gap();
        do_reset();
        gap_ptr[0] = 2; gap_left[0] = 4;
        load_gold();
        wait_out(0, 4);
        check_gold("gap");
        n_checks++; if (viol !== 0) $display("FAIL read_without_valid: got %0d want 0", viol); else n_pass++;
    endtask

    task automatic test_id_wrap();
        int id_exp[10];
        id_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        do_reset();
        for (int i = 0; i < 10; i++) in_mem[1][i] = {32'h0, 32'hC0DE0000 + 32'(i), 32'h12345678 ^ 32'(i * 7)};
        in_len[1] = 10;
        wait_out(1, 10);
        n_checks++; if (out_cnt[1] !== 10) $display("FAIL idw_count: got %0d want 10", out_cnt[1]); else n_pass++;
        n_checks++; if (rd_cnt[1] !== 10) $display("FAIL idw_reads: got %0d want 10", rd_cnt[1]); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (cap_vec[1][i] !== in_mem[1][i]) $display("FAIL idw_word%0d: got %h want %h", i, cap_vec[1][i], in_mem[1][i]); else n_pass++;
            n_checks++; if (cap_id[1][i] !== 8'(id_exp[i])) $display("FAIL idw_id%0d: got %0d want %0d", i, cap_id[1][i], id_exp[i]); else n_pass++;
            n_checks++; if (cap_last[1][i] !== 1'(i % 2)) $display("FAIL idw_last%0d: got %b want %0d", i, cap_last[1][i], i % 2); else n_pass++;
        end
    endtask

    task automatic test_narrow();
        logic [479:0] stream;
        logic [39:0]  v[12];
        do_reset();
        for (int k = 0; k < 12; k++) begin
            v[k] = {8'(k * 17 + 3), 32'h9E3779B9 ^ 32'(k * 4099)};
            stream[479 - 40 * k -: 40] = v[k];
        end
        for (int j = 0; j < 5; j++) in_mem[2][j] = stream[479 - 96 * j -: 96];
        in_len[2] = 5;
        wait_out(2, 12);
        n_checks++; if (out_cnt[2] !== 12) $display("FAIL nar_count: got %0d want 12", out_cnt[2]); else n_pass++;
        n_checks++; if (rd_cnt[2] !== 5) $display("FAIL nar_reads: got %0d want 5", rd_cnt[2]); else n_pass++;
        for (int k = 0; k < 12; k++) begin
            n_checks++; if (cap_vec[2][k] !== {v[k], 56'h0}) $display("FAIL nar_word%0d: got %h want %h", k, cap_vec[2][k], {v[k], 56'h0}); else n_pass++;
            n_checks++; if (cap_id[2][k] !== 8'(k)) $display("FAIL nar_id%0d: got %0d want %0d", k, cap_id[2][k], k); else n_pass++;
            n_checks++; if (cap_last[2][k] !== 1'b1) $display("FAIL nar_last%0d: got %b want 1", k, cap_last[2][k]); else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        load_gold();
        for (int c = 0; c < 50 && rd_cnt[0] < 1; c++) @(posedge clk);
        #2;
        rst = 1'b1;
        in_len[0] = 0;
        #1;
        n_checks++; if (oval[0] !== 1'b0) $display("FAIL mrst_valid: got %b want 0", oval[0]); else n_pass++;
        n_checks++; if (ov[0] !== 96'h0) $display("FAIL mrst_vector: got %h want 0", ov[0]); else n_pass++;
        n_checks++; if (oid[0] !== 8'h0) $display("FAIL mrst_id: got %0d want 0", oid[0]); else n_pass++;
        n_checks++; if (olast[0] !== 1'b0) $display("FAIL mrst_last: got %b want 0", olast[0]); else n_pass++;
        n_checks++; if (ord[0] !== 1'b0) $display("FAIL mrst_read: got %b want 0", ord[0]); else n_pass++;
        @(posedge clk); #2;
        clear_ctrl();
        rst = 1'b0;
        load_gold();
        wait_out(0, 4);
        check_gold("mrst");
    endtask

`ifdef VEC_CAT_POPCNT_EN
    task automatic test_popcnt();
        logic [7:0] pe[3];
        pe = '{8'd128, 8'd0, 8'd4};
        do_reset();
        in_mem[0][0] = 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF;
        in_mem[0][1] = 96'hFFFFFFFF_00000000_00000000;
        in_mem[0][2] = 96'h0;
        in_mem[0][3] = 96'h00000000_00000000_0000000F;
        in_len[0] = 4;
        wait_out(0, 6);
        n_checks++; if (out_cnt[0] !== 6) $display("FAIL pop_count: got %0d want 6", out_cnt[0]); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (cap_pop[2 * k + 1] !== pe[k]) $display("FAIL pop%0d: got %0d want %0d", k, cap_pop[2 * k + 1], pe[k]); else n_pass++;
        end
    endtask
`endif

    initial begin
        gold_v[0] = 96'h0123456789ABCDEF_FEDCBA98;
        gold_v[1] = 96'h76543210_00000000_00000000;
        gold_v[2] = 96'hDEADBEEF_CAFEBABE_01234567;
        gold_v[3] = 96'h89ABCDEF_00000000_00000000;
        gold_id[0] = 8'd0; gold_id[1] = 8'd0; gold_id[2] = 8'd1; gold_id[3] = 8'd1;
        gold_l[0] = 1'b0;  gold_l[1] = 1'b1;  gold_l[2] = 1'b0;  gold_l[3] = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_gap();
        test_id_wrap();
        test_narrow();
        test_mid_reset();
`ifdef VEC_CAT_POPCNT_EN
        test_popcnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
